multicycle_controller: RTL and testbench

//  Multi-cycle control FSM for the datapath.
//  - Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//  - Handshakes with instruction source (instr_valid) and data memory (mem_ready).
//  - Adds a resumable HALT state, illegal-opcode detection and a retired-instruction counter.
//  - Drives datapath enables, ALU control and PC update for the core top level.

---
 rtl/multicycle_controller.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, with a resumable HALT state,
// illegal-opcode detection and retired/illegal instruction counters.
// Enables are decoded combinationally from the state register and the
// latched opcode so that each step asserts its controls in its own cycle.
module multicycle_controller #(
  parameter int unsigned          OPCODE_W = 3,
  parameter int unsigned          ALU_W    = 3,
  parameter int unsigned          CNT_W    = 16,
  parameter logic [OPCODE_W-1:0]  OP_STORE = OPCODE_W'(0),
  parameter logic [OPCODE_W-1:0]  OP_LOAD  = OPCODE_W'(1),
  parameter logic [OPCODE_W-1:0]  OP_ADD   = OPCODE_W'(2),
  parameter logic [OPCODE_W-1:0]  OP_BEQ   = OPCODE_W'(5),
  parameter logic [OPCODE_W-1:0]  OP_STOP  = OPCODE_W'(7)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                ir_load,
  output logic                pc_enable,
  output logic                branch_taken,
  output logic                reg_we,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ALU_W-1:0]    alu_control,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic [CNT_W-1:0]    illegal_cnt
);

  // ALU operation encodings driven during EXECUTE and MEMORY
  localparam logic [ALU_W-1:0] ALU_STORE = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_LOAD  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_BEQ   = ALU_W'(5);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [OPCODE_W-1:0]   op_q;
  logic [OPCODE_W-1:0]   op_d;
  logic [CNT_W-1:0]      retired_q;
  logic [CNT_W-1:0]      illegal_q;
  logic                  retire_inc;
  logic                  illegal_inc;

  // Opcode classification of the latched instruction
  logic op_is_store;
  logic op_is_load;
  logic op_is_add;
  logic op_is_beq;
  logic op_is_stop;
  logic op_is_defined;

  assign op_is_store   = (op_q == OP_STORE);
  assign op_is_load    = (op_q == OP_LOAD);
  assign op_is_add     = (op_q == OP_ADD);
  assign op_is_beq     = (op_q == OP_BEQ);
  assign op_is_stop    = (op_q == OP_STOP);
  assign op_is_defined = op_is_store | op_is_load | op_is_add |
                         op_is_beq   | op_is_stop;

  // ALU control selected from the latched opcode
  logic [ALU_W-1:0] alu_sel;

  always_comb begin
    alu_sel = ALU_STORE;
    if (op_is_load) begin
      alu_sel = ALU_LOAD;
    end else if (op_is_add) begin
      alu_sel = ALU_ADD;
    end else if (op_is_beq) begin
      alu_sel = ALU_BEQ;
    end
  end

  // State, latched opcode and counters; synchronous reset wins over all inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
      illegal_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      if (retire_inc) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (illegal_inc) begin
        illegal_q <= illegal_q + CNT_W'(1);
      end
    end
  end

  // Next-state and control decode; all outputs forced low while reset is high
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    retire_inc   = 1'b0;
    illegal_inc  = 1'b0;
    ir_load      = 1'b0;
    pc_enable    = 1'b0;
    branch_taken = 1'b0;
    reg_we       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    alu_control  = '0;
    halted       = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_load = instr_valid;
        if (instr_valid) begin
          op_d    = opcode;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (op_is_stop) begin
          retire_inc = 1'b1;
          state_d    = S_HALT;
        end else if (!op_is_defined) begin
          // Undefined opcode: flag it and skip over the instruction
          illegal     = 1'b1;
          illegal_inc = 1'b1;
          pc_enable   = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        alu_control = alu_sel;
        if (op_is_store || op_is_load) begin
          state_d = S_MEMORY;
        end else if (op_is_beq) begin
          pc_enable    = 1'b1;
          branch_taken = zero;
          retire_inc   = 1'b1;
          state_d      = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end

      S_MEMORY: begin
        // Hold the request until memory completes; no timeout
        mem_req     = 1'b1;
        mem_we      = op_is_store;
        alu_control = alu_sel;
        if (mem_ready) begin
          if (op_is_store) begin
            pc_enable  = 1'b1;
            retire_inc = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end

      S_WRITEBACK: begin
        reg_we     = 1'b1;
        pc_enable  = 1'b1;
        retire_inc = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: begin
        // instr_valid is ignored here; only resume leaves HALT
        halted = 1'b1;
        if (resume) begin
          pc_enable = 1'b1;
          state_d   = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      ir_load      = 1'b0;
      pc_enable    = 1'b0;
      branch_taken = 1'b0;
      reg_we       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      alu_control  = '0;
      halted       = 1'b0;
      illegal      = 1'b0;
    end
  end

  // Counter outputs read as zero during reset
  assign retired_cnt = reset ? '0 : retired_q;
  assign illegal_cnt = reset ? '0 : illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle vector bench for multicycle_controller, plus LOAD
// latency sequences with a variable number of memory wait cycles.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [2:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        resume;
  logic        ir_load;
  logic        pc_enable;
  logic        branch_taken;
  logic        reg_we;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  alu_control;
  logic        halted;
  logic        illegal;
  logic [15:0] retired_cnt;
  logic [15:0] illegal_cnt;

  multicycle_controller dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .resume       (resume),
    .ir_load      (ir_load),
    .pc_enable    (pc_enable),
    .branch_taken (branch_taken),
    .reg_we       (reg_we),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .alu_control  (alu_control),
    .halted       (halted),
    .illegal      (illegal),
    .retired_cnt  (retired_cnt),
    .illegal_cnt  (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word layout: ir_load pc_enable branch_taken reg_we mem_req mem_we alu[2:0] halted illegal
  localparam logic [10:0] IL  = 11'd1024;
  localparam logic [10:0] PE  = 11'd512;
  localparam logic [10:0] BT  = 11'd256;
  localparam logic [10:0] RW  = 11'd128;
  localparam logic [10:0] MQ  = 11'd64;
  localparam logic [10:0] MW  = 11'd32;
  localparam logic [10:0] ALD = 11'd4;
  localparam logic [10:0] AAD = 11'd8;
  localparam logic [10:0] ABQ = 11'd20;
  localparam logic [10:0] HL  = 11'd2;
  localparam logic [10:0] IG  = 11'd1;
  localparam logic [10:0] NO  = 11'd0;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [2:0]  op;
    logic        z;
    logic        mr;
    logic        res;
    logic [10:0] exp;
    logic [15:0] ret;
    logic [15:0] ill;
  } vec_t;

  typedef struct {
    int          idx;
    logic [10:0] exp;
    logic [15:0] ret;
    logic [15:0] ill;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void v(input logic rst, input logic iv, input logic [2:0] op,
                            input logic z, input logic mr, input logic res,
                            input logic [10:0] exp, input int ret, input int ill);
    vec_t t;
    t.rst = rst; t.iv = iv; t.op = op; t.z = z; t.mr = mr; t.res = res;
    t.exp = exp; t.ret = 16'(ret); t.ill = 16'(ill);
    vecs.push_back(t);
  endfunction

  function automatic logic [10:0] outs();
    return {ir_load, pc_enable, branch_taken, reg_we, mem_req, mem_we,
            alu_control, halted, illegal};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, req);
    end
  endtask

  // LOAD with w wait cycles: mem_req high w+1 cycles, FETCH..WRITEBACK spans 5+w cycles
  task automatic run_load(input int w, input int ret_before);
    int cyc;
    int mq;
    bit done;
    cyc  = 1;
    mq   = 0;
    done = 0;
    @(negedge clk);
    reset = 0; instr_valid = 1; opcode = 3'd1; mem_ready = 0; zero = 0; resume = 0;
    #2;
    chk("load_irload", w, 32'(ir_load), 32'd1);
    while (!done && cyc < 50) begin
      @(negedge clk);
      instr_valid = 0;
      mem_ready   = 0;
      #1;
      if (mem_req) begin
        mq++;
        chk("load_memwe", w, 32'(mem_we), 32'd0);
        if (mq == w + 1) mem_ready = 1;
      end
      #1;
      cyc++;
      if (reg_we) done = 1;
    end
    chk("load_done", w, 32'(done), 32'd1);
    chk("load_latency", w, 32'(cyc), 32'(5 + w));
    chk("load_memreq_cycles", w, 32'(mq), 32'(w + 1));
    @(negedge clk);
    mem_ready = 0;
    #2;
    chk("load_retired", w, 32'(retired_cnt), 32'(ret_before + 1));
  endtask

  initial begin
    reset = 1; instr_valid = 1; opcode = 3'd2; zero = 0; mem_ready = 0; resume = 0;

    // reset held two cycles with an ADD presented
    v(1,1,3'd2,0,0,0, NO, 0,0);
    v(1,1,3'd2,0,0,0, NO, 0,0);
    // ADD
    v(0,1,3'd2,0,0,0, IL, 0,0);
    v(0,0,3'd0,0,0,0, NO, 0,0);
    v(0,0,3'd0,0,0,0, AAD, 0,0);
    v(0,0,3'd0,0,0,0, RW|PE, 0,0);
    // LOAD, mem_ready low 3 cycles
    v(0,1,3'd1,0,0,0, IL, 1,0);
    v(0,0,3'd0,0,0,0, NO, 1,0);
    v(0,0,3'd0,0,0,0, ALD, 1,0);
    v(0,0,3'd0,0,0,0, MQ|ALD, 1,0);
    v(0,0,3'd0,0,0,0, MQ|ALD, 1,0);
    v(0,0,3'd0,0,0,0, MQ|ALD, 1,0);
    v(0,0,3'd0,0,1,0, MQ|ALD, 1,0);
    v(0,0,3'd0,0,0,0, RW|PE, 1,0);
    // BEQ taken
    v(0,1,3'd5,1,0,0, IL, 2,0);
    v(0,0,3'd0,1,0,0, NO, 2,0);
    v(0,0,3'd0,1,0,0, PE|BT|ABQ, 2,0);
    // BEQ not taken
    v(0,1,3'd5,0,0,0, IL, 3,0);
    v(0,0,3'd0,0,0,0, NO, 3,0);
    v(0,0,3'd0,0,0,0, PE|ABQ, 3,0);
    // STORE, mem_ready high outside MEMORY must be ignored
    v(0,1,3'd0,0,1,0, IL, 4,0);
    v(0,0,3'd0,0,1,0, NO, 4,0);
    v(0,0,3'd0,0,1,0, NO, 4,0);
    v(0,0,3'd0,0,0,0, MQ|MW, 4,0);
    v(0,0,3'd0,0,1,0, MQ|MW|PE, 4,0);
    // STOP, HALT ignores instr_valid for 10 cycles, then resume
    v(0,1,3'd7,0,0,0, IL, 5,0);
    v(0,0,3'd0,0,0,0, NO, 5,0);
    for (int k = 0; k < 10; k++) v(0,1,3'd2,0,0,0, HL, 6,0);
    v(0,0,3'd0,0,0,1, HL|PE, 6,0);
    v(0,0,3'd0,0,0,0, NO, 6,0);
    // undefined opcode 3
    v(0,1,3'd3,0,0,0, IL, 6,0);
    v(0,0,3'd0,0,0,0, IG|PE, 6,0);
    // STORE interrupted by reset while in MEMORY
    v(0,1,3'd0,0,0,0, IL, 6,1);
    v(0,0,3'd0,0,0,0, NO, 6,1);
    v(0,0,3'd0,0,0,0, NO, 6,1);
    v(0,0,3'd0,0,0,0, MQ|MW, 6,1);
    v(1,0,3'd0,0,1,0, NO, 0,0);
    v(0,0,3'd0,0,1,0, NO, 0,0);

    foreach (vecs[i]) begin
      sb_t e;
      sb_t p;
      @(negedge clk);
      reset       = vecs[i].rst;
      instr_valid = vecs[i].iv;
      opcode      = vecs[i].op;
      zero        = vecs[i].z;
      mem_ready   = vecs[i].mr;
      resume      = vecs[i].res;
      p.idx = i; p.exp = vecs[i].exp; p.ret = vecs[i].ret; p.ill = vecs[i].ill;
      sb.push_back(p);
      #2;
      e = sb.pop_front();
      chk("outputs", e.idx, 32'(outs()), 32'(e.exp));
      chk("retired_cnt", e.idx, 32'(retired_cnt), 32'(e.ret));
      chk("illegal_cnt", e.idx, 32'(illegal_cnt), 32'(e.ill));
      chk("one_hot_we", e.idx, 32'($countones({reg_we, mem_we, branch_taken}) <= 1), 32'd1);
    end

    // state is FETCH with counters cleared after the table
    run_load(0, 0);
    run_load(3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
